pipeline_stage_register: RTL and testbench
==========================================

PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath payload width in bits.
REQ-002 SHALL have parameter CTRL_W, default 16: control payload width in bits (write enables, HALT, op, byteenable and similar fields).
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width in bits.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous squash of all held entries.
REQ-007 in_valid  in  1  upstream stage presents an entry.
REQ-008 in_ready  out  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control payload.
REQ-010 in_data  in  DATA_W  upstream datapath payload.
REQ-011 out_valid  out  1  downstream entry is present.
REQ-012 out_ready  in  1  downstream stage consumes the entry this cycle.
REQ-013 out_ctrl  out  CTRL_W  downstream control payload, gated.
REQ-014 out_data  out  DATA_W  downstream datapath payload.
REQ-015 occupancy  out  2  number of held entries, 0..2.
REQ-016 stall_count  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-017 SHALL hold two entries, each {valid, ctrl, data}: MAIN drives the outputs; SKID catches one entry while MAIN is blocked.
REQ-018 SHALL drive in_ready = !SKID.valid, a pure function of registered state with no combinational path from out_ready.
REQ-019 A transfer in SHALL occur on a rising edge when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-020 SHALL drive out_valid = MAIN.valid, out_data = MAIN.data, and out_ctrl = MAIN.ctrl when MAIN.valid, else all zeros, so bubbles never carry side effects.
REQ-021 MAIN empty, or emptying by a transfer out, with SKID empty: an accepted entry SHALL load into MAIN; latency in-to-out SHALL be exactly 1 cycle.
REQ-022 MAIN full, no transfer out, entry accepted: the entry SHALL load into SKID; occupancy becomes 2 and in_ready drops next cycle.
REQ-023 SKID full and transfer out: SKID SHALL move to MAIN and SKID.valid clears; there is no simultaneous accept, since in_ready=0.
REQ-024 Entries SHALL leave strictly in arrival order; no entry is dropped or duplicated.
REQ-025 occupancy SHALL equal MAIN.valid + SKID.valid.
REQ-026 flush SHALL clear both valid bits and zero both ctrl fields at the next edge; data fields are unchanged.
REQ-027 flush SHALL take priority over a same-cycle accept: the incoming entry is discarded. A same-cycle transfer out still counts as consumed downstream.
REQ-028 stall_count SHALL increment by 1 on each edge where out_valid && !out_ready, saturate at 2^CNT_W-1, and clear only on reset; flush does not clear it.
REQ-029 Full throughput SHALL hold: with out_ready held 1, one entry is accepted and one delivered every cycle and occupancy never exceeds 1.

Reset
REQ-030 While reset is high, SHALL force MAIN, SKID, and stall_count to zero immediately, independent of clk.
REQ-031 Outputs during and after reset SHALL be: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_count=0, in_ready=1.
REQ-032 No transfer SHALL occur on an edge where reset is high.
REQ-033 Reset mid-operation SHALL discard all held entries.
REQ-034 The first accept SHALL be possible on the first edge after reset deasserts.

Verification (DATA_W=32, CTRL_W=8, CNT_W=4)
REQ-035 Streaming: in_valid=1 and out_ready=1 for 4 cycles with data 0x10..0x13 -> out_data 0x10..0x13 on consecutive cycles, each 1 cycle after its accept; occupancy<=1.
REQ-036 Back-pressure: send A=0xA, B=0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB delivered; in_ready=1 one cycle after 0xA leaves.
REQ-037 Flush: occupancy=2 with ctrl 0xFF, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0x00, and the incoming entry never appears.
REQ-038 Saturation: out_valid=1, out_ready=0 for 20 cycles -> stall_count reads 15 and holds; flush leaves it at 15; reset clears it to 0.
REQ-039 Async reset: assert reset between edges with occupancy=2 -> outputs match REQ-031 before the next edge; accept on the first edge after release -> out_valid=1 one cycle later.

Source files
------------

// File: rtl/pipeline_stage_register.sv
// Two-entry pipeline stage register (MAIN + SKID) with valid/ready handshake.
// in_ready depends only on registered state. out_ctrl is gated to zero on
// bubbles. flush squashes held entries. A saturating counter counts
// back-pressure cycles.
module pipeline_stage_register #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  // MAIN drives the outputs. SKID holds the one entry that arrives while MAIN is blocked.
  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_take_in;
  logic w_take_out;
  logic w_stalled;
  logic w_stall_sat;

  // Handshake qualifiers. in_ready comes only from SKID, so out_ready has no combinational path to it.
  assign in_ready    = !r_skid_valid;
  assign w_take_in   = in_valid && !r_skid_valid;
  assign w_take_out  = r_main_valid && out_ready;
  assign w_stalled   = r_main_valid && !out_ready;
  assign w_stall_sat = (r_stall_count == {CNT_W{1'b1}});

  // Output drive. ctrl is gated so that a bubble never carries write enables or a HALT.
  assign out_valid   = r_main_valid;
  assign out_data    = r_main_data;
  assign out_ctrl    = r_main_valid ? r_main_ctrl : '0;
  assign occupancy   = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign stall_count = r_stall_count;

  // Entry storage: fill, skid, drain and flush. flush overrides any accept.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the data fields are reset too, because out_data must read zero after reset.
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Data fields keep their values. Only valid bits and ctrl are squashed.
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
    end else if (r_skid_valid) begin
      // SKID is full and in_ready is low. Promote SKID to MAIN once MAIN drains.
      if (w_take_out) begin
        // NOTE: non-blocking assignments read the pre-edge SKID values here, so the move is safe in one step.
        r_main_valid <= 1'b1;
        r_main_ctrl  <= r_skid_ctrl;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end
    end else if (!r_main_valid || w_take_out) begin
      // MAIN is free this edge. An accepted entry goes straight into MAIN (1-cycle latency).
      r_main_valid <= w_take_in;
      if (w_take_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end
    end else if (w_take_in) begin
      // MAIN is blocked, so the accepted entry goes into SKID.
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= in_ctrl;
      r_skid_data  <= in_data;
    end
  end

  // Back-pressure counter. It saturates at its maximum and only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stalled && !w_stall_sat) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed bench for pipeline_stage_register with DATA_W=32, CTRL_W=8, CNT_W=4.
// Inputs change 1 time unit after each rising edge. Outputs are sampled at that same point.
module tb_pipeline_stage_register;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_stage_register #(
    .DATA_W(32),
    .CTRL_W(8),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_count(stall_count)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".out_valid"},   32'(out_valid),   32'd0);
    check({tag, ".out_ctrl"},    32'(out_ctrl),    32'd0);
    check({tag, ".out_data"},    out_data,         32'd0);
    check({tag, ".occupancy"},   32'(occupancy),   32'd0);
    check({tag, ".stall_count"}, 32'(stall_count), 32'd0);
    check({tag, ".in_ready"},    32'(in_ready),    32'd1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Streaming: accept on the first edge after reset, 1-cycle latency, occupancy stays at 1
    in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'h01;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h10 + 32'(i);
      tick();
      check($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d.data", i),  out_data,       32'h10 + 32'(i));
      check($sformatf("stream%0d.ctrl", i),  32'(out_ctrl),  32'h01);
      check($sformatf("stream%0d.occ", i),   32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end.valid", 32'(out_valid),   32'd0);
    check("stream_end.ctrl",  32'(out_ctrl),    32'd0);
    check("stream_end.stall", 32'(stall_count), 32'd0);

    // Back-pressure: A goes into MAIN, B goes into SKID, then both drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h02; in_data = 32'hA;
    tick();
    check("bp_a.occ",      32'(occupancy), 32'd1);
    check("bp_a.in_ready", 32'(in_ready),  32'd1);
    in_data = 32'hB;
    tick();
    check("bp_b.occ",      32'(occupancy),   32'd2);
    check("bp_b.in_ready", 32'(in_ready),    32'd0);
    check("bp_b.data",     out_data,         32'hA);
    check("bp_b.stall",    32'(stall_count), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_a_out.data", out_data, 32'hA);
    tick();
    check("bp_drain1.data",     out_data,       32'hB);
    check("bp_drain1.occ",      32'(occupancy), 32'd1);
    check("bp_drain1.in_ready", 32'(in_ready),  32'd1);
    tick();
    check("bp_drain2.valid", 32'(out_valid),   32'd0);
    check("bp_drain2.occ",   32'(occupancy),   32'd0);
    check("bp_drain2.stall", 32'(stall_count), 32'd1);

    // Flush with two entries held and an incoming entry in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'h21;
    tick();
    in_data = 32'h22;
    tick();
    check("fl_full.occ",  32'(occupancy), 32'd2);
    check("fl_full.ctrl", 32'(out_ctrl),  32'hFF);
    flush = 1'b1; in_data = 32'h23;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.occ",      32'(occupancy),   32'd0);
    check("fl.valid",    32'(out_valid),   32'd0);
    check("fl.ctrl",     32'(out_ctrl),    32'd0);
    check("fl.data",     out_data,         32'h21);
    check("fl.in_ready", 32'(in_ready),    32'd1);
    check("fl.stall",    32'(stall_count), 32'd3);

    // flush takes priority over an accept while in_ready=1
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_pri.valid", 32'(out_valid), 32'd0);
    tick();
    check("fl_pri2.valid", 32'(out_valid), 32'd0);
    check("fl_pri2.data",  out_data,       32'h21);

    // Saturation: 20 stalled cycles after the stall count already reads 3
    in_valid = 1'b1; in_ctrl = 8'h03; in_data = 32'h30;
    tick();
    in_valid = 1'b0;
    check("sat_start.stall", 32'(stall_count), 32'd3);
    for (int i = 0; i < 20; i++) tick();
    check("sat.stall", 32'(stall_count), 32'd15);
    tick();
    check("sat_hold.stall", 32'(stall_count), 32'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_flush.stall", 32'(stall_count), 32'd15);
    check("sat_flush.occ",   32'(occupancy),   32'd0);

    // Async reset between edges with two entries held
    in_valid = 1'b1; in_ctrl = 8'h04; in_data = 32'h40;
    tick();
    in_data = 32'h41;
    tick();
    in_valid = 1'b0;
    check("ar_full.occ", 32'(occupancy), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    #1;
    reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'h05; in_data = 32'h50;
    tick();
    in_valid = 1'b0;
    check("ar_accept.valid", 32'(out_valid), 32'd1);
    check("ar_accept.data",  out_data,       32'h50);
    check("ar_accept.ctrl",  32'(out_ctrl),  32'h05);
    tick();
    check("ar_drain.valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
